pipelined_alu: RTL and testbench



---
 rtl/pipelined_alu.sv | 188 ++++++++++++++++++
 tb/tb_pipelined_alu.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_alu
// Description : Registered execute-stage ALU with valid/ready handshakes on
//               both sides. Single-cycle ops: add, sub, and, or, sll, sra,
//               srl, xor, slt. Optional iterative signed multiply enabled by
//               defining PIPELINED_ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  data_operandA,
    input  logic [DATA_WIDTH-1:0]  data_operandB,
    input  logic [4:0]             ctrl_ALUopcode,
    input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_result,
    output logic                   isNotEqual,
    output logic                   isLessThan,
    output logic                   overflow
);

    localparam int         c_msb     = DATA_WIDTH - 1;
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_mul  = 1'b1;

    logic [0:0]            r_state;
    logic                  w_accept;
    logic                  w_load_alu;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_add_ovf;
    logic                  w_sub_ovf;
    logic                  w_lt;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_ne_flag;
    logic                  w_lt_flag;
    logic                  w_ovf_flag;

    assign in_ready = (!out_valid || out_ready) && (r_state == c_st_idle);
    assign w_accept = in_valid && in_ready;

    // Signed overflow: operands with the relevant sign relation whose result
    // sign differs from A. The less-than flag folds overflow back in.
    assign w_sum     = data_operandA + data_operandB;
    assign w_diff    = data_operandA - data_operandB;
    assign w_add_ovf = (data_operandA[c_msb] == data_operandB[c_msb]) && (w_sum[c_msb] != data_operandA[c_msb]);
    assign w_sub_ovf = (data_operandA[c_msb] != data_operandB[c_msb]) && (w_diff[c_msb] != data_operandA[c_msb]);
    assign w_lt      = w_diff[c_msb] ^ w_sub_ovf;

    // Single-cycle operation decode; unsupported opcodes yield all zeros.
    always_comb begin
        w_res      = '0;
        w_ne_flag  = 1'b0;
        w_lt_flag  = 1'b0;
        w_ovf_flag = 1'b0;
        case (ctrl_ALUopcode)
            5'b00000: begin w_res = w_sum;  w_ovf_flag = w_add_ovf; end
            5'b00001: begin
                w_res      = w_diff;
                w_ovf_flag = w_sub_ovf;
                w_ne_flag  = (data_operandA != data_operandB);
                w_lt_flag  = w_lt;
            end
            5'b00010: w_res = data_operandA & data_operandB;
            5'b00011: w_res = data_operandA | data_operandB;
            5'b00100: w_res = data_operandA << ctrl_shiftamt;
            5'b00101: w_res = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
            5'b00110: w_res = data_operandA >> ctrl_shiftamt;
            5'b00111: w_res = data_operandA ^ data_operandB;
            5'b01000: w_res = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            default:  w_res = '0;
        endcase
    end

`ifdef PIPELINED_ALU_MUL_EN
    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [SHAMT_WIDTH-1:0]  r_cnt;
    logic                    r_mul_done;
    logic                    w_is_mul;
    logic                    w_last;
    logic [2*DATA_WIDTH-1:0] w_addend;
    logic [2*DATA_WIDTH-1:0] w_acc_next;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic                    w_mul_write;
    logic                    w_mul_ovf;

    // The multiplier's MSB carries negative weight, so the last partial
    // product is subtracted rather than added (two's-complement multiplier).
    assign w_is_mul    = (ctrl_ALUopcode == 5'b01001);
    assign w_load_alu  = w_accept && !w_is_mul;
    assign w_last      = (r_cnt == SHAMT_WIDTH'(DATA_WIDTH - 1));
    assign w_addend    = r_mplier[0] ? (w_last ? -r_mcand : r_mcand) : '0;
    assign w_acc_next  = r_acc + w_addend;
    assign w_prod      = r_mul_done ? r_acc : w_acc_next;
    assign w_mul_write = (r_state == c_st_mul) && (w_last || r_mul_done) && (!out_valid || out_ready);
    assign w_mul_ovf   = (|w_prod[2*DATA_WIDTH-1:c_msb]) && !(&w_prod[2*DATA_WIDTH-1:c_msb]);

    // Multiply FSM: latch operands, one shift-add per cycle, hold the
    // finished product if the output register is still occupied.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_mul_done <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept && w_is_mul) begin
                        r_mcand    <= {{DATA_WIDTH{data_operandA[c_msb]}}, data_operandA};
                        r_mplier   <= data_operandB;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_mul_done <= 1'b0;
                        r_state    <= c_st_mul;
                    end
                end
                default: begin
                    if (w_mul_write) begin
                        r_state <= c_st_idle;
                    end else if (!r_mul_done) begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_mul_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
`else
    assign w_load_alu = w_accept;

    // Without the multiplier every operation completes in IDLE.
    always_ff @(posedge clock) begin
        r_state <= c_st_idle;
    end
`endif

    // Output register: cleared on transfer, reloaded on acceptance or on
    // multiply completion; otherwise held stable under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_load_alu) begin
                out_valid   <= 1'b1;
                data_result <= w_res;
                isNotEqual  <= w_ne_flag;
                isLessThan  <= w_lt_flag;
                overflow    <= w_ovf_flag;
            end
`ifdef PIPELINED_ALU_MUL_EN
            if (w_mul_write) begin
                out_valid   <= 1'b1;
                data_result <= w_prod[DATA_WIDTH-1:0];
                isNotEqual  <= 1'b0;
                isLessThan  <= 1'b0;
                overflow    <= w_mul_ovf;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_alu
// Description : Scoreboard bench for pipelined_alu (DATA_WIDTH = 32). Covers
//               multiply or its unsupported-opcode behaviour depending on
//               PIPELINED_ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_alu;

    localparam int DW = 32;
    localparam int SW = 5;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          ne;
        logic          lt;
        logic          ovf;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_operandA = '0;
    logic [DW-1:0] data_operandB = '0;
    logic [4:0]    ctrl_ALUopcode = '0;
    logic [SW-1:0] ctrl_shiftamt = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] data_result;
    logic          isNotEqual;
    logic          isLessThan;
    logic          overflow;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    pipelined_alu #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .isNotEqual(isNotEqual),
        .isLessThan(isLessThan), .overflow(overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model, written directly from the opcode table.
    function automatic exp_t model(input logic [4:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [SW-1:0] sh);
        exp_t                 m;
        logic signed [DW-1:0] sa;
        longint               p;
        m  = '0;
        sa = a;
        case (op)
            5'd0: begin m.res = a + b; m.ovf = (a[DW-1] == b[DW-1]) && (m.res[DW-1] != a[DW-1]); end
            5'd1: begin
                m.res = a - b;
                m.ovf = (a[DW-1] != b[DW-1]) && (m.res[DW-1] != a[DW-1]);
                m.ne  = (a != b);
                m.lt  = ($signed(a) < $signed(b));
            end
            5'd2: m.res = a & b;
            5'd3: m.res = a | b;
            5'd4: m.res = a << sh;
            5'd5: m.res = sa >>> sh;
            5'd6: m.res = a >> sh;
            5'd7: m.res = a ^ b;
            5'd8: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef PIPELINED_ALU_MUL_EN
            5'd9: begin
                p     = longint'($signed(a)) * longint'($signed(b));
                m.res = p[DW-1:0];
                m.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            end
`endif
            default: m = '0;
        endcase
        return m;
    endfunction

    // Scoreboard: each output transfer is popped and compared in order.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got res=%h with empty scoreboard", data_result);
            end else begin
                e = sb.pop_front();
                if ({data_result, isNotEqual, isLessThan, overflow} !== e) begin
                    n_err++;
                    $display("FAIL result: got res=%h ne=%b lt=%b ovf=%b, expected res=%h ne=%b lt=%b ovf=%b",
                             data_result, isNotEqual, isLessThan, overflow, e.res, e.ne, e.lt, e.ovf);
                end
            end
        end
    end

    // Presents one operation and waits (bounded) until it is accepted.
    task automatic issue(input logic [4:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [SW-1:0] sh);
        bit acc = 0;
        in_valid = 1'b1; ctrl_ALUopcode = op; data_operandA = a;
        data_operandB = b; ctrl_shiftamt = sh;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back(model(op, a, b, sh));
                acc = 1;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: op=%b never accepted", op);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clock);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({out_valid, data_result, isNotEqual, isLessThan, overflow, in_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b res=%h flags=%b%b%b rdy=%b, expected 0/0/000/1",
                     out_valid, data_result, isNotEqual, isLessThan, overflow, in_ready);
        end
        // Reset must also clear a held, nonzero result.
        @(posedge clock); #1;
        out_ready = 1'b0;
        issue(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clock);
        n_vec++;
        if ({out_valid, data_result, overflow, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_clear: got v=%b res=%h ovf=%b rdy=%b, expected 0/0/0/1",
                     out_valid, data_result, overflow, in_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_arith();
        issue(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        n_vec++;
        @(negedge clock);
        if (out_valid !== 1'b1 || data_result !== 32'h8000_0000 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL add_latency: got v=%b res=%h ovf=%b, expected 1/80000000/1", out_valid, data_result, overflow);
        end
        @(posedge clock); #1;
        issue(5'd1, 32'h8000_0000, 32'd1, 5'd0);
        issue(5'd1, 32'd5, 32'd5, 5'd0);
        issue(5'd1, 32'd3, 32'd9, 5'd0);
        issue(5'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        issue(5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(5'd0, 32'h8000_0000, 32'h8000_0000, 5'd0);
        issue(5'd8, 32'h8000_0000, 32'd1, 5'd0);
        issue(5'd8, 32'd7, 32'hFFFF_FFFE, 5'd0);
        drain();
    endtask

    task automatic test_shifts();
        for (int op = 4; op <= 6; op++) begin
            issue(5'(op), 32'h8000_0010, 32'd0, 5'd4);
            issue(5'(op), 32'hA5A5_5A5A, 32'd0, 5'd0);
            issue(5'(op), 32'h8000_0001, 32'd0, 5'd31);
        end
        drain();
    endtask

    task automatic test_logic();
        issue(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        issue(5'd3, 32'hF0F0_1234, 32'h0FF0_0000, 5'd0);
        issue(5'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd3);
        issue(5'd10, 32'h1234_5678, 32'h1234_5678, 5'd3);
        issue(5'd31, 32'hFFFF_FFFF, 32'd1, 5'd1);
`ifndef PIPELINED_ALU_MUL_EN
        issue(5'd9, 32'd6, 32'd7, 5'd0);
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b1 || data_result !== 32'd0) begin
            n_err++;
            $display("FAIL mul_unsupported: got v=%b res=%h, expected 1/00000000", out_valid, data_result);
        end
        @(posedge clock); #1;
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        int start;
        out_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 8; i++) issue(5'(i), 32'h1000 + 32'(i), 32'h33 * 32'(i), 5'(i));
        n_vec++;
        if (cyc - start !== 8) begin
            n_err++;
            $display("FAIL throughput: got %0d cycles for 8 ops, expected 8", cyc - start);
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(5'd0, 32'd1, 32'd2, 5'd0);
        in_valid = 1'b1; ctrl_ALUopcode = 5'd0; data_operandA = 32'd3; data_operandB = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_result !== 32'd3) begin
                n_err++;
                $display("FAIL hold: got rdy=%b v=%b res=%h, expected 0/1/00000003", in_ready, out_valid, data_result);
            end
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: got rdy=%b, expected 1", in_ready);
        end else begin
            sb.push_back(model(5'd0, 32'd3, 32'd4, 5'd0));
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b1 || data_result !== 32'd7) begin
            n_err++;
            $display("FAIL second_op: got v=%b res=%h, expected 1/00000007", out_valid, data_result);
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_drop: got v=%b, expected 0", out_valid);
        end
        @(posedge clock); #1;
        drain();
    endtask

`ifdef PIPELINED_ALU_MUL_EN
    task automatic test_mul();
        int busy;
        out_ready = 1'b1;
        issue(5'd9, 32'hFFFF_FFFD, 32'd7, 5'd0);
        busy = 0;
        for (int i = 0; i < DW; i++) begin
            @(negedge clock);
            if (in_ready === 1'b0 && out_valid === 1'b0) busy++;
            @(posedge clock); #1;
        end
        @(negedge clock);
        n_vec++;
        if (busy !== DW || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mul_latency: got busy=%0d v=%b, expected %0d/1", busy, out_valid, DW);
        end
        @(posedge clock); #1;
        issue(5'd9, 32'h0001_0000, 32'h0001_0000, 5'd0);
        issue(5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        issue(5'd9, 32'h0000_B504, 32'hFFFF_4AFC, 5'd0);
        drain();
        issue(5'd9, 32'd123, 32'd456, 5'd0);
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mul_abort: got rdy=%b v=%b, expected 1/0", in_ready, out_valid);
        end
        busy = 0;
        for (int i = 0; i < DW + 4; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) busy++;
        end
        n_vec++;
        if (busy !== 0) begin
            n_err++;
            $display("FAIL mul_abort_emit: got %0d valid cycles, expected 0", busy);
        end
        @(posedge clock); #1;
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] a, b;
        logic [4:0]    op;
        logic [SW-1:0] sh;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            op = 5'($urandom_range(0, 11));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
            sh = 5'($urandom);
            ctrl_ALUopcode = op; data_operandA = a; data_operandB = b; ctrl_shiftamt = sh;
            @(negedge clock);
            if (in_valid && in_ready) sb.push_back(model(op, a, b, sh));
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shifts();
        test_logic();
        test_back_to_back();
        test_backpressure();
`ifdef PIPELINED_ALU_MUL_EN
        test_mul();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
